hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline-control counterpart to the forwarding unit. The forwarding unit consumes in-flight results; this block detects the dependencies that forwarding cannot satisfy in time.
- It then holds PC and IF/ID and injects bubbles into ID/EX for the required number of cycles, flushes IF/ID on a taken branch, and keeps saturating performance counters.
- Sits in the ID stage beside the forwarding unit, on the same pipeline-register fields.

Parameters:
REG_ADDR_WIDTH, 5, register address width
CNT_WIDTH, 32, width of performance counters

Ports:
clk  input  1  pipeline clock
rst  input  1  synchronous active-high reset
IF_ID_inst_opcode  input  7  opcode of instruction in ID
IF_ID_rs1  input  REG_ADDR_WIDTH  IF/ID.RegisterRs1
IF_ID_rs2  input  REG_ADDR_WIDTH  IF/ID.RegisterRs2
ID_EX_reg_wr_en  input  1  ID/EX reg write enable
ID_EX_mem_rd_en  input  1  ID/EX instruction is a load
ID_EX_rd  input  REG_ADDR_WIDTH  ID/EX.RegisterRd
EX_MEM_mem_rd_en  input  1  EX/MEM instruction is a load
EX_MEM_rd  input  REG_ADDR_WIDTH  EX/MEM.RegisterRd
branch_taken  input  1  branch in ID resolved taken (valid only when not stalling)
mem_busy  input  1  data memory not ready; freezes whole pipeline
pc_wr_en  output  1  PC update enable
IF_ID_wr_en  output  1  IF/ID register write enable
IF_ID_flush  output  1  replace IF/ID contents with NOP
ID_EX_bubble  output  1  load NOP control into ID/EX
stall_cycles  output  CNT_WIDTH  saturating count of hazard-stall cycles
flush_count  output  CNT_WIDTH  saturating count of taken-branch flushes

Behaviour:
- Only the clock and reset (clk, rst: one clock, synchronous active-high reset) are pre-decided. Everything below is the specification of this block.
- Operand use decode:
  - uses_rs1 = opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
  - uses_rs2 = opcode in {0110011, 0100011, 1100011}.
  - is_branch = opcode == 1100011.
  - A match requires producer rd != 0 and the relevant uses_rsX.
- Required stall count `need` (0..2), computed combinationally each cycle:
  - ID_EX load matching IF_ID rs, consumer is a branch: need = 2.
  - ID_EX load matching IF_ID rs, consumer is not a branch: need = 1.
  - ID_EX_reg_wr_en non-load matching, consumer is a branch: need = 1.
  - EX_MEM load matching, consumer is a branch: need = 1.
  - Otherwise need = 0. The maximum of all applicable terms is taken.
- FSM states RUN, HOLD; 2-bit register `remain`.
  - RUN, need > 0:
    - Assert the stall this same cycle (zero latency): pc_wr_en = 0, IF_ID_wr_en = 0, ID_EX_bubble = 1.
    - remain <= need - 1.
    - Go to HOLD if need == 2, else stay in RUN.
  - HOLD: stall asserted unconditionally; remain decrements; return to RUN when remain reaches 0. Hazard inputs are ignored in HOLD.
  - RUN, need == 0: pc_wr_en = 1, IF_ID_wr_en = 1, ID_EX_bubble = 0.
- Flush:
  - IF_ID_flush = branch_taken & not stalling & !mem_busy.
  - Combinational, one cycle per taken branch; flush_count increments on that cycle.
  - branch_taken during a stall cycle is ignored.
- mem_busy:
  - Overrides everything: pc_wr_en = 0, IF_ID_wr_en = 0, ID_EX_bubble = 0, IF_ID_flush = 0.
  - FSM state, remain and counters are frozen; stall_cycles does not count these cycles.
  - Hazard detection resumes when mem_busy deasserts.
- stall_cycles increments on every cycle where ID_EX_bubble = 1. Both counters saturate at all-ones; no wrap.
- Reset (synchronous, also mid-stall):
  - State = RUN, remain = 0, counters = 0.
  - Outputs in the reset cycle: pc_wr_en = 0, IF_ID_wr_en = 0, IF_ID_flush = 0, ID_EX_bubble = 1.
  - Normal evaluation resumes the first cycle after rst deasserts.
- Simultaneous hazard and branch_taken in RUN: the stall wins, no flush. The branch is re-evaluated after the stall.

Test Plan:
- Load x5 in ID_EX (mem_rd_en = 1, rd = 5); ID holds add (0110011) with rs2 = 5 -> one cycle of pc_wr_en = 0, ID_EX_bubble = 1, then RUN; stall_cycles = 1.
- Load x7 in ID_EX; ID holds branch (1100011) with rs1 = 7 -> two consecutive stall cycles (RUN -> HOLD -> RUN), stall_cycles = 2, no flush even with branch_taken = 1.
- ID_EX add rd = 3; ID holds branch rs2 = 3 -> one stall cycle. Repeat with rd = 0 -> no stall. Repeat with LUI consumer using rs1 = 3 -> no stall.
- branch_taken = 1 with no hazard -> IF_ID_flush = 1 for exactly one cycle, flush_count = 1. Same with mem_busy = 1 -> no flush, count unchanged.
- mem_busy asserted in the HOLD cycle for 3 cycles -> outputs frozen (pc_wr_en = 0, bubble = 0), remain held, stall_cycles unchanged. After release the remaining stall cycle completes.
- rst asserted in HOLD -> next cycle RUN with counters = 0. Preload counters to all-ones-minus-1, run 3 stall cycles -> stall_cycles = all-ones, held.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detection: stalls PC and IF/ID and bubbles ID/EX for
// dependencies forwarding cannot cover, flushes IF/ID on taken branches.
module hazard_stall_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                IF_ID_inst_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2,
    input  logic                      ID_EX_reg_wr_en,
    input  logic                      ID_EX_mem_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] ID_EX_rd,
    input  logic                      EX_MEM_mem_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
    input  logic                      branch_taken,
    input  logic                      mem_busy,
    output logic                      pc_wr_en,
    output logic                      IF_ID_wr_en,
    output logic                      IF_ID_flush,
    output logic                      ID_EX_bubble,
    output logic [CNT_WIDTH-1:0]      stall_cycles,
    output logic [CNT_WIDTH-1:0]      flush_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic {RUN, HOLD} state_t;

    state_t     state, state_next;
    logic [1:0] remain, remain_next;

    logic       uses_rs1, uses_rs2, is_branch;
    logic       ex_match, mem_match;
    logic [1:0] need;
    logic       stall;

    // Operand-use decode of the consumer sitting in ID.
    always_comb begin
        uses_rs1  = !((IF_ID_inst_opcode == OP_LUI)   ||
                      (IF_ID_inst_opcode == OP_AUIPC) ||
                      (IF_ID_inst_opcode == OP_JAL));
        uses_rs2  = (IF_ID_inst_opcode == OP_REG)   ||
                    (IF_ID_inst_opcode == OP_STORE) ||
                    (IF_ID_inst_opcode == OP_BRANCH);
        is_branch = (IF_ID_inst_opcode == OP_BRANCH);
    end

    // x0 is never a real producer, so rd == 0 can never create a dependency.
    always_comb begin
        ex_match  = (ID_EX_rd != '0) &&
                    ((uses_rs1 && (IF_ID_rs1 == ID_EX_rd)) ||
                     (uses_rs2 && (IF_ID_rs2 == ID_EX_rd)));
        mem_match = (EX_MEM_rd != '0) &&
                    ((uses_rs1 && (IF_ID_rs1 == EX_MEM_rd)) ||
                     (uses_rs2 && (IF_ID_rs2 == EX_MEM_rd)));
    end

    // Terms are ordered by increasing cost so the last hit is the maximum.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        need = 2'd0;
        if (EX_MEM_mem_rd_en && mem_match && is_branch)
            need = 2'd1;
        if (ID_EX_reg_wr_en && !ID_EX_mem_rd_en && ex_match && is_branch)
            need = 2'd1;
        if (ID_EX_mem_rd_en && ex_match)
            need = is_branch ? 2'd2 : 2'd1;
    end

    // Next state and outputs; reset beats mem_busy, mem_busy beats everything else.
    always_comb begin
        state_next   = state;
        remain_next  = remain;
        stall        = 1'b0;
        pc_wr_en     = 1'b1;
        IF_ID_wr_en  = 1'b1;
        ID_EX_bubble = 1'b0;
        IF_ID_flush  = 1'b0;

        if (rst) begin
            pc_wr_en     = 1'b0;
            IF_ID_wr_en  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_wr_en    = 1'b0;
            IF_ID_wr_en = 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (need != 2'd0) begin
                        stall       = 1'b1;
                        remain_next = need - 2'd1;
                        state_next  = (need == 2'd2) ? HOLD : RUN;
                    end else begin
                        IF_ID_flush = branch_taken;
                    end
                end
                HOLD: begin
                    stall       = 1'b1;
                    remain_next = (remain != 2'd0) ? remain - 2'd1 : 2'd0;
                    if (remain <= 2'd1)
                        state_next = RUN;
                end
            endcase

            if (stall) begin
                pc_wr_en     = 1'b0;
                IF_ID_wr_en  = 1'b0;
                ID_EX_bubble = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            remain       <= 2'd0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state  <= state_next;
            remain <= remain_next;
            if (ID_EX_bubble && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (IF_ID_flush && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench: directed hazard scenarios plus randomized traffic, all
// compared against a stall-budget reference model derived from the hazard rules.
module tb_hazard_stall_unit;

    localparam int AW   = 5;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] ADD    = 7'b0110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] ADDI   = 7'b0010011;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = ADDI;
    logic [AW-1:0] rs1 = '0, rs2 = '0, ex_rd = '0, mem_rd = '0;
    logic          ex_wr = 1'b0, ex_ld = 1'b0, mem_ld = 1'b0, bt = 1'b0, mb = 1'b0;
    logic          pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: outstanding stall cycles and the two saturating counts.
    int m_pending = 0;
    int m_stall   = 0;
    int m_flush   = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .IF_ID_inst_opcode (opcode),
        .IF_ID_rs1         (rs1),
        .IF_ID_rs2         (rs2),
        .ID_EX_reg_wr_en   (ex_wr),
        .ID_EX_mem_rd_en   (ex_ld),
        .ID_EX_rd          (ex_rd),
        .EX_MEM_mem_rd_en  (mem_ld),
        .EX_MEM_rd         (mem_rd),
        .branch_taken      (bt),
        .mem_busy          (mb),
        .pc_wr_en          (pc_wr_en),
        .IF_ID_wr_en       (IF_ID_wr_en),
        .IF_ID_flush       (IF_ID_flush),
        .ID_EX_bubble      (ID_EX_bubble),
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int need_of();
        bit u1, u2, br, exm, mm;
        int n;
        u1  = !(opcode inside {LUI, AUIPC, JAL});
        u2  = opcode inside {ADD, STORE, BRANCH};
        br  = (opcode == BRANCH);
        exm = (ex_rd != 0) && ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
        mm  = (mem_rd != 0) && ((u1 && rs1 == mem_rd) || (u2 && rs2 == mem_rd));
        n = 0;
        if (ex_ld && exm)            n = br ? 2 : 1;
        if (ex_wr && !ex_ld && exm && br && n < 1) n = 1;
        if (mem_ld && mm && br && n < 1)           n = 1;
        return n;
    endfunction

    // One cycle: apply inputs, compare against the model, advance the model.
    task automatic step(input logic r, input logic [6:0] op, input int a1, input int a2,
                        input logic ew, input logic el, input int erd,
                        input logic ml, input int mrd, input logic b, input logic busy);
        logic e_pc, e_ifid, e_flush, e_bub;
        int   nd;
        @(negedge clk);
        rst = r; opcode = op; rs1 = AW'(a1); rs2 = AW'(a2);
        ex_wr = ew; ex_ld = el; ex_rd = AW'(erd);
        mem_ld = ml; mem_rd = AW'(mrd); bt = b; mb = busy;
        #1;
        e_pc = 1'b1; e_ifid = 1'b1; e_flush = 1'b0; e_bub = 1'b0;
        if (r) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1;
        end else if (busy) begin
            e_pc = 1'b0; e_ifid = 1'b0;
        end else if (m_pending > 0) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1;
        end else begin
            nd = need_of();
            if (nd > 0) begin
                e_pc = 1'b0; e_ifid = 1'b0; e_bub = 1'b1;
            end else begin
                e_flush = b;
            end
        end
        check("pc_wr_en",     pc_wr_en,     e_pc);
        check("IF_ID_wr_en",  IF_ID_wr_en,  e_ifid);
        check("IF_ID_flush",  IF_ID_flush,  e_flush);
        check("ID_EX_bubble", ID_EX_bubble, e_bub);
        check("stall_cycles", stall_cycles, m_stall);
        check("flush_count",  flush_count,  m_flush);

        if (r) begin
            m_pending = 0; m_stall = 0; m_flush = 0;
        end else if (!busy) begin
            if (m_pending > 0) m_pending--;
            else begin
                nd = need_of();
                if (nd > 0) m_pending = nd - 1;
            end
            if (e_bub && m_stall < CMAX) m_stall++;
            if (e_flush && m_flush < CMAX) m_flush++;
        end
    endtask

    task automatic idle(input logic b, input logic busy);
        step(1'b0, ADDI, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, b, busy);
    endtask

    initial begin
        logic [6:0] ops [8];
        ops = '{LUI, AUIPC, JAL, ADD, STORE, BRANCH, LOAD, ADDI};

        repeat (2) @(negedge clk);
        step(1'b1, ADDI, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

        // Load x5 feeding add rs2: one stall cycle.
        step(1'b0, ADD, 1, 5, 1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("load_add_stalls", stall_cycles, 1);

        // Load x7 feeding branch rs1: two stall cycles, taken branch ignored.
        step(1'b0, BRANCH, 7, 0, 1'b1, 1'b1, 7, 1'b0, 0, 1'b1, 1'b0);
        step(1'b0, BRANCH, 7, 0, 1'b1, 1'b1, 7, 1'b0, 0, 1'b1, 1'b0);
        idle(1'b0, 1'b0);
        check("load_branch_stalls", stall_cycles, 3);
        check("load_branch_noflush", flush_count, 0);

        // ALU producer feeding branch; rd = 0 and LUI consumer do not stall.
        step(1'b0, BRANCH, 0, 3, 1'b1, 1'b0, 3, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, BRANCH, 0, 0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, LUI,    3, 3, 1'b1, 1'b0, 3, 1'b0, 0, 1'b0, 1'b0);
        // EX/MEM load feeding branch: one stall.
        step(1'b0, BRANCH, 4, 0, 1'b0, 1'b0, 0, 1'b1, 4, 1'b0, 1'b0);

        // Taken branch flush, then suppressed by mem_busy.
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b0, 1'b0);

        // mem_busy in the HOLD cycle freezes the pending stall.
        step(1'b0, BRANCH, 7, 0, 1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        repeat (3) idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Reset while in HOLD.
        step(1'b0, BRANCH, 7, 0, 1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, BRANCH, 7, 0, 1'b1, 1'b1, 7, 1'b0, 0, 1'b1, 1'b0);
        idle(1'b0, 1'b0);
        check("reset_clears_stalls", stall_cycles, 0);

        // Drive the stall counter into saturation.
        repeat (CMAX + 4) step(1'b0, ADD, 5, 0, 1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("stall_saturated", stall_cycles, CMAX);
        repeat (CMAX + 3) idle(1'b1, 1'b0);
        idle(1'b0, 1'b0);
        check("flush_saturated", flush_count, CMAX);
        step(1'b1, ADDI, 0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);

        // Randomized traffic with a small register pool to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ops[$urandom_range(0, 7)],
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
